// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction-fetch unit.
//   PC_W / INSTR_W / PC_STEP : default widths and sequential step
//   fetch_state_t            : fetch FSM state encoding
//   ifid_t                   : {instr, pc} pair held by IF/ID and the skid buffer
package fetch_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } ifid_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry holding register for a fetched {instr, pc}.
//   clk, reset : clock, async active-high reset
//   load       : capture din (entry becomes valid)
//   drain      : entry consumed (entry becomes empty)
//   flush      : discard entry; highest priority
//   din / dout : entry in / out
//   valid      : entry holds data
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  drain,
  input  logic  flush,
  input  ifid_t din,
  output logic  valid,
  output ifid_t dout
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: reads imem at pc, latches the word into IF/ID, and
// drives next_pc / pc_en back to the program counter. A one-entry skid
// buffer absorbs the word that arrives while decode is stalled; branch
// redirects from ID flush everything and reload the PC.
//   clk, reset                    : clock, async active-high reset
//   pc / next_pc / pc_en          : PC interface (PC loads next_pc when pc_en)
//   imem_req/addr/ack/rdata       : instruction memory read port
//   id_valid/instr/pc, id_ready   : IF/ID latch towards decode
//   branch_taken / branch_target  : redirect from ID
//
// state | meaning
// BOOT  | one idle cycle after reset, no request
// FETCH | requesting imem at pc, loading IF/ID
// FULL  | skid holds a word behind a stalled IF/ID, fetch paused
//
// The skid entry uses the package ifid_t, so non-default widths must be
// changed in fetch_pkg as well.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W    = fetch_pkg::PC_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W,
  parameter int PC_STEP = fetch_pkg::PC_STEP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    next_pc,
  output logic               pc_en,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  input  logic               id_ready,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target
);

  fetch_state_t state;

  logic  branch_act;
  logic  ifid_free;
  logic  ack_ok;
  logic  accept;
  logic  skid_load;
  logic  skid_drain;
  logic  skid_valid;
  ifid_t skid_din;
  ifid_t skid_dout;

  assign branch_act = branch_taken && (state != BOOT);
  assign ifid_free  = !id_valid || id_ready;
  // A usable response: only in FETCH, and a branch discards it.
  assign ack_ok     = (state == FETCH) && imem_ack && !branch_taken;
  assign accept     = ack_ok && ifid_free;
  assign skid_load  = ack_ok && !ifid_free;
  assign skid_drain = (state == FULL) && id_ready && !branch_taken;

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign pc_en     = branch_act || ack_ok;
  // Wraps modulo 2^PC_W by width truncation.
  assign next_pc   = branch_act ? branch_target : pc + PC_W'(PC_STEP);

  assign skid_din.instr = imem_rdata;
  assign skid_din.pc    = pc;

  fetch_skid_buffer u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .drain (skid_drain),
    .flush (branch_act),
    .din   (skid_din),
    .valid (skid_valid),
    .dout  (skid_dout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= BOOT;
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
    end else begin
      unique case (state)
        BOOT: begin
          state <= FETCH;
        end
        FETCH: begin
          if (branch_taken) begin
            id_valid <= 1'b0;
          end else if (accept) begin
            id_valid <= 1'b1;
            id_instr <= imem_rdata;
            id_pc    <= pc;
          end else if (skid_load) begin
            state <= FULL;
          end else if (id_ready) begin
            id_valid <= 1'b0;
          end
        end
        FULL: begin
          if (branch_taken) begin
            id_valid <= 1'b0;
            state    <= FETCH;
          end else if (id_ready) begin
            id_valid <= skid_valid;
            id_instr <= skid_dout.instr;
            id_pc    <= skid_dout.pc;
            state    <= FETCH;
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  logic        clk;
  logic        reset;
  logic [7:0]  pc;
  logic [7:0]  next_pc;
  logic        pc_en;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [7:0]  id_pc;
  logic        id_ready;
  logic        branch_taken;
  logic [7:0]  branch_target;

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_q[$];
  logic [7:0] sb_exp;

  instr_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .next_pc       (next_pc),
    .pc_en         (pc_en),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_ready      (id_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter register and instruction memory of the environment.
  always @(posedge clk or posedge reset) begin
    if (reset) pc <= 8'h00;
    else if (pc_en) pc <= next_pc;
  end
  assign imem_rdata = {24'h0, imem_addr} ^ KEY;

  // Scoreboard: every instruction decode consumes must be the next expected one.
  always @(negedge clk) begin
    if (!reset && id_valid && id_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected id_pc=%h id_instr=%h (queue empty)", id_pc, id_instr);
      end else begin
        sb_exp = exp_q.pop_front();
        if (id_pc !== sb_exp || id_instr !== ({24'h0, sb_exp} ^ KEY))
          $display("FAIL sb_word got pc=%h instr=%h want pc=%h instr=%h",
                   id_pc, id_instr, sb_exp, {24'h0, sb_exp} ^ KEY);
        else passes++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (id_valid !== 1'b0 || id_pc !== 8'h00 || id_instr !== 32'h0 || imem_req !== 1'b0 || pc_en !== 1'b0)
      $display("FAIL reset_vals got v=%b pc=%h i=%h req=%b en=%b want 0", id_valid, id_pc, id_instr, imem_req, pc_en);
    else passes++;
    tick();
    reset = 1'b0;
    imem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || pc_en !== 1'b0)
      $display("FAIL boot_idle got req=%b en=%b want 0 0", imem_req, pc_en);
    else passes++;
    tick();
    imem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00)
      $display("FAIL boot_fetch got req=%b addr=%h want 1 00", imem_req, imem_addr);
    else passes++;
    tick();
  endtask

  task automatic test_stream;
    for (int k = 0; k < 8; k++) exp_q.push_back(8'(k * 4));
    imem_ack = 1'b1;
    id_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (id_valid !== 1'b1 || pc !== 8'(k * 4))
          $display("FAIL stream_rate cyc=%0d got v=%b pc=%h want 1 %h", k, id_valid, pc, 8'(k * 4));
        else passes++;
      end
      tick();
    end
    imem_ack = 1'b0;
    tick();
    checks++;
    if (exp_q.size() != 0 || id_valid !== 1'b0)
      $display("FAIL stream_drain got left=%0d v=%b want 0 0", exp_q.size(), id_valid);
    else passes++;
  endtask

  task automatic test_stall;
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h24);
    exp_q.push_back(8'h28);
    imem_ack = 1'b1;
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (pc_en !== 1'b1 || next_pc !== 8'h28)
      $display("FAIL stall_skid_cap got en=%b next=%h want 1 28", pc_en, next_pc);
    else passes++;
    tick();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || pc_en !== 1'b0 || id_valid !== 1'b1 || id_pc !== 8'h20 || pc !== 8'h28)
        $display("FAIL stall_full got req=%b en=%b v=%b idpc=%h pc=%h want 0 0 1 20 28",
                 imem_req, pc_en, id_valid, id_pc, pc);
      else passes++;
      tick();
    end
    id_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || id_pc !== 8'h24)
      $display("FAIL stall_resume got req=%b idpc=%h want 1 24", imem_req, id_pc);
    else passes++;
    tick();
    imem_ack = 1'b0;
    tick();
    checks++;
    if (exp_q.size() != 0 || pc !== 8'h2C)
      $display("FAIL stall_drain got left=%0d pc=%h want 0 2c", exp_q.size(), pc);
    else passes++;
  endtask

  task automatic test_branch;
    exp_q.push_back(8'h2C);
    exp_q.push_back(8'h40);
    imem_ack = 1'b1;
    id_ready = 1'b1;
    tick();
    branch_taken = 1'b1;
    branch_target = 8'h40;
    @(negedge clk);
    checks++;
    if (pc_en !== 1'b1 || next_pc !== 8'h40)
      $display("FAIL branch_redirect got en=%b next=%h want 1 40", pc_en, next_pc);
    else passes++;
    tick();
    branch_taken = 1'b0;
    @(negedge clk);
    checks++;
    if (id_valid !== 1'b0 || imem_addr !== 8'h40)
      $display("FAIL branch_flush got v=%b addr=%h want 0 40", id_valid, imem_addr);
    else passes++;
    tick();
    imem_ack = 1'b0;
    tick();
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL branch_drain got left=%0d want 0", exp_q.size());
    else passes++;
  endtask

  task automatic test_branch_full;
    exp_q.push_back(8'h80);
    imem_ack = 1'b1;
    id_ready = 1'b0;
    tick();
    tick();
    branch_taken = 1'b1;
    branch_target = 8'h80;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || pc_en !== 1'b1 || next_pc !== 8'h80)
      $display("FAIL bfull_redirect got req=%b en=%b next=%h want 0 1 80", imem_req, pc_en, next_pc);
    else passes++;
    tick();
    branch_taken = 1'b0;
    id_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h80)
      $display("FAIL bfull_flush got v=%b req=%b addr=%h want 0 1 80", id_valid, imem_req, imem_addr);
    else passes++;
    tick();
    imem_ack = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || id_valid !== 1'b0)
      $display("FAIL bfull_drain got left=%0d v=%b want 0 0", exp_q.size(), id_valid);
    else passes++;
    tick();
  endtask

  task automatic test_wrap;
    exp_q.push_back(8'hFC);
    exp_q.push_back(8'h00);
    id_ready = 1'b1;
    branch_taken = 1'b1;
    branch_target = 8'hFC;
    tick();
    branch_taken = 1'b0;
    imem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (pc_en !== 1'b1 || next_pc !== 8'h00)
      $display("FAIL wrap_next got en=%b next=%h want 1 00", pc_en, next_pc);
    else passes++;
    tick();
    tick();
    imem_ack = 1'b0;
    tick();
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL wrap_drain got left=%0d want 0", exp_q.size());
    else passes++;
  endtask

  task automatic test_reset_mid;
    imem_ack = 1'b1;
    id_ready = 1'b0;
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 8'h04)
      $display("FAIL rmid_setup got v=%b idpc=%h want 1 04", id_valid, id_pc);
    else passes++;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 8'h00 || imem_req !== 1'b0 || pc_en !== 1'b0)
      $display("FAIL rmid_async got v=%b i=%h idpc=%h req=%b en=%b want 0", id_valid, id_instr, id_pc, imem_req, pc_en);
    else passes++;
    tick();
    reset = 1'b0;
    id_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || pc_en !== 1'b0 || id_valid !== 1'b0)
      $display("FAIL rmid_boot got req=%b en=%b v=%b want 0 0 0", imem_req, pc_en, id_valid);
    else passes++;
    tick();
    imem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00)
      $display("FAIL rmid_fetch got req=%b addr=%h want 1 00", imem_req, imem_addr);
    else passes++;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    imem_ack = 1'b0;
    id_ready = 1'b0;
    branch_taken = 1'b0;
    branch_target = 8'h00;
    tick();
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_branch_full();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch unit on the consumer side of the program counter. It takes the current `pc`, reads instruction memory at that address, and places the returned word with its address in the IF/ID latch for decode. It then returns `next_pc` and the PC enable (`pc_en`, wired to the PC's `E`) to the PC. It also absorbs decode-side stalls with a one-entry skid buffer and applies branch redirects from ID.

## Interface
- `PC_W`, default 8: PC and instruction-address width, byte addressed.
- `INSTR_W`, default 32: instruction word width.
- `PC_STEP`, default 4: sequential increment in bytes.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `pc`  in  PC_W  current PC value from the program counter.
- `next_pc`  out  PC_W  next value for the PC; loaded only when `pc_en`=1.
- `pc_en`  out  1  PC update enable (PC `E`).
- `imem_req`  out  1  instruction-memory read request.
- `imem_addr`  out  PC_W  read address; always equals `pc`.
- `imem_ack`  in  1  memory has valid `imem_rdata` for `imem_addr` this cycle.
- `imem_rdata`  in  INSTR_W  instruction word.
- `id_valid`  out  1  IF/ID latch holds a valid instruction.
- `id_instr`  out  INSTR_W  latched instruction.
- `id_pc`  out  PC_W  address of `id_instr`.
- `id_ready`  in  1  decode consumes IF/ID this cycle (0 means stall).
- `branch_taken`  in  1  redirect request from ID.
- `branch_target`  in  PC_W  redirect address.

## Operation
- FSM states are `BOOT`, `FETCH` and `FULL`. `reset` forces `BOOT`.
- **BOOT** lasts exactly one cycle after reset deasserts.
  - `imem_req`=0 and `pc_en`=0.
  - Always goes to `FETCH`.
- **FETCH**
  - `imem_req`=1.
  - A response is accepted when `imem_ack`=1, `branch_taken`=0, and IF/ID is free (`id_valid`=0 or `id_ready`=1).
    - IF/ID loads `{imem_rdata, pc}` and `id_valid`=1.
    - `pc_en`=1 and `next_pc`=`pc`+`PC_STEP`.
  - If `imem_ack`=1, `branch_taken`=0 and IF/ID is occupied and stalled:
    - The skid buffer captures `{imem_rdata, pc}`.
    - `pc_en`=1 and `next_pc`=`pc`+`PC_STEP`.
    - State goes to `FULL`.
  - If `id_ready`=1 and no response is accepted, `id_valid` clears.
- **FULL**
  - `imem_req`=0 and `pc_en`=0.
  - When `id_ready`=1, IF/ID loads from the skid buffer, the skid buffer empties, and state returns to `FETCH`.
- **Branch** (`branch_taken`=1, any state except `BOOT`):
  - `pc_en`=1 and `next_pc`=`branch_target`.
  - IF/ID and the skid buffer are flushed (`id_valid`=0).
  - Any same-cycle `imem_ack` data is discarded.
  - State goes to `FETCH`.
  - A branch takes priority over ack, stall and skid drain.
- **Arithmetic:** `pc`+`PC_STEP` is modulo 2^PC_W, so 0xFC+4 = 0x00 with no flag.
- **Defaults:** when `pc_en`=0, `next_pc`=`pc`+`PC_STEP`, so the value is don't-care but defined.
- **Memory contract:** `imem_ack` refers to the address on `imem_addr` in the same cycle. An address change while `imem_req`=1 is legal, so no kill tracking is required.

## Timing
- Reset values:
  - `id_valid`=0, `id_instr`=0, `id_pc`=0.
  - `imem_req`=0, `pc_en`=0.
  - Skid buffer empty.
- `pc_en`, `next_pc` and `imem_req` are combinational from state and inputs. IF/ID and skid contents are registered.
- **Latency:** with a single-cycle ack, the instruction at `pc` appears on `id_*` one edge after the ack cycle.
- **Throughput:** one instruction per cycle when `imem_ack`=1 and `id_ready`=1 continuously.
- **Branch latency:** the first instruction from the target reaches `id_valid` two edges after `branch_taken`. The PC updates at the first edge; the ack comes in the following cycle.
- **Reset mid-operation:** all outputs return to their reset values asynchronously. The in-flight ack is ignored.

## Structure
- A shared package `fetch_pkg` holds:
  - `PC_W`, `INSTR_W`, `PC_STEP` defaults;
  - the `fetch_state_t` enum (`BOOT`, `FETCH`, `FULL`);
  - the packed struct `ifid_t` {`instr`, `pc`}.
- Sub-module `fetch_skid_buffer`: a one-entry `ifid_t` holding register with load, drain and flush controls. It is instantiated once.
- The FSM, next-PC mux and IF/ID latch live in the top module.

## Test plan
- **Reset and boot:** assert `reset` mid-fetch, with `id_valid`=1 -> all outputs are reset immediately. After release: one `BOOT` cycle with `imem_req`=0, then `imem_req`=1 with `imem_addr`=0x00.
- **Streaming:** `pc`=0x00, `imem_ack`=1 and `id_ready`=1 continuously, rdata = address XOR 0xA5A5A5A5 -> `id_pc` sequence 0x00, 0x04, 0x08, … with one instruction per cycle and matching `id_instr`.
- **Stall and skid:** hold `id_ready`=0 for 3 cycles while acking -> one extra word is captured, state is `FULL`, `pc_en`=0 and `imem_req`=0. Release `id_ready` -> the skid word is presented next with no instruction lost or duplicated.
- **Branch:** `branch_taken`=1, target 0x40, in the same cycle as `imem_ack` -> `next_pc`=0x40 and `pc_en`=1. The acked word never appears, `id_valid`=0 the next cycle, and the next `id_pc`=0x40.
- **Branch in FULL:** branch while the skid buffer is full -> both entries are flushed and fetch resumes at the target.
- **Wrap-around:** `pc`=0xFC acked -> `next_pc`=0x00 and the next `id_pc`=0x00.
